// File: rtl/noc_input_buffer.sv
// Per-port NoC input stage: link-side FIFO, XY route computation from head flits,
// packet route hold, orphan drop. Define NOC_IBUF_STATS_EN to add the drop_count port.
module noc_input_buffer #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int COORD_W    = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH-1:0]   link_flit,
    input  logic                    link_valid,
    output logic                    link_ready,
    output logic [FLIT_WIDTH-1:0]   flit_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [2:0]              route_port,
    output logic                    err_orphan,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef NOC_IBUF_STATS_EN
    ,
    output logic [15:0]             drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]      FULL_COUNT = CW'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X_C     = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C     = COORD_W'(MY_Y);

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_N     = 3'd1;
    localparam logic [2:0] P_E     = 3'd2;
    localparam logic [2:0] P_S     = 3'd3;
    localparam logic [2:0] P_W     = 3'd4;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state_q, state_d;
    logic [FLIT_WIDTH-1:0]  mem_q [DEPTH];
    logic [FLIT_WIDTH-1:0]  mem_d [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [2:0]             route_q, route_d;

    logic [FLIT_WIDTH-1:0]  head_flit;
    logic [1:0]             head_type;
    logic [COORD_W-1:0]     dest_x;
    logic [COORD_W-1:0]     dest_y;
    logic [2:0]             route_calc;
    logic                   not_empty;
    logic                   orphan;
    logic                   fire;
    logic                   push;
    logic                   pop;

    assign head_flit = mem_q[rd_ptr_q];
    assign head_type = head_flit[FLIT_WIDTH-1 -: 2];
    assign dest_x    = head_flit[FLIT_WIDTH-3 -: COORD_W];
    assign dest_y    = head_flit[FLIT_WIDTH-3-COORD_W -: COORD_W];

    // Dimension-ordered routing: resolve X fully before Y.
    always_comb begin
        route_calc = P_LOCAL;
        if (dest_x > MY_X_C) begin
            route_calc = P_E;
        end else if (dest_x < MY_X_C) begin
            route_calc = P_W;
        end else if (dest_y > MY_Y_C) begin
            route_calc = P_N;
        end else if (dest_y < MY_Y_C) begin
            route_calc = P_S;
        end
    end

    // Output decode; a body/tail at the front while IDLE has no head and is dropped.
    always_comb begin
        not_empty  = (count_q != '0);
        orphan     = not_empty && (state_q == IDLE) && !head_type[0];
        valid_out  = not_empty && !orphan;
        link_ready = (count_q != FULL_COUNT);
        fire       = valid_out && ready_in;
        push       = link_valid && link_ready;
        pop        = fire || orphan;
        err_orphan = orphan;
        flit_out   = head_flit;
        occupancy  = count_q;
        route_port = P_LOCAL;
        if (valid_out) begin
            route_port = (state_q == ACTIVE) ? route_q : route_calc;
        end
    end

    // A head or single arriving mid-packet closes the current packet on the held route.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            IDLE: begin
                if (fire && (head_type == T_HEAD)) begin
                    state_d = ACTIVE;
                    route_d = route_calc;
                end
            end
            ACTIVE: begin
                if (fire && (head_type != T_BODY)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = link_flit;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            route_q  <= P_LOCAL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

`ifdef NOC_IBUF_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (orphan && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Scoreboard bench for noc_input_buffer at MY=(1,1), DEPTH=4: directed flits with
// hand-computed routes queued as expectations, checked by a negedge monitor.
module tb_noc_input_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] link_flit = '0;
    logic        link_valid = 1'b0;
    logic        link_ready;
    logic [63:0] flit_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [2:0]  route_port;
    logic        err_orphan;
    logic [2:0]  occupancy;
`ifdef NOC_IBUF_STATS_EN
    logic [15:0] drop_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] flit;
        logic [2:0]  route;
    } exp_t;

    exp_t exp_q[$];

    noc_input_buffer #(
        .FLIT_WIDTH(64),
        .DEPTH(4),
        .COORD_W(4),
        .MY_X(1),
        .MY_Y(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .link_flit(link_flit),
        .link_valid(link_valid),
        .link_ready(link_ready),
        .flit_out(flit_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .route_port(route_port),
        .err_orphan(err_orphan),
        .occupancy(occupancy)
`ifdef NOC_IBUF_STATS_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                       input logic [3:0] dy, input logic [53:0] pl);
        return {t, dx, dy, pl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] f);
        link_flit  = f;
        link_valid = 1'b1;
    endtask

    task automatic expect_out(input logic [63:0] f, input logic [2:0] r);
        exp_t e;
        e.flit  = f;
        e.route = r;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted output flit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_flit: got %0h expected none at %0t", flit_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("flit_out", flit_out, e.flit);
                chk("route_port", {61'd0, route_port}, {61'd0, e.route});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] f [5];

        // Reset state
        repeat (2) tick;
        rst = 1'b0;
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_link_ready", 64'(link_ready), 64'd1);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_route_port", 64'(route_port), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);

        // Single flit dest(3,1) -> E
        ready_in = 1'b1;
        f[0] = mk(2'b11, 4'd3, 4'd1, 54'h1111);
        send(f[0]);
        expect_out(f[0], 3'd2);
        tick;
        link_valid = 1'b0;
        chk("single_valid", 64'(valid_out), 64'd1);
        chk("single_route", 64'(route_port), 64'd2);
        chk("single_occ", 64'(occupancy), 64'd1);
        tick;
        chk("single_occ_after", 64'(occupancy), 64'd0);
        chk("single_valid_after", 64'(valid_out), 64'd0);

        // Head dest(0,2) -> W, held for body and tail
        f[0] = mk(2'b01, 4'd0, 4'd2, 54'h2001);
        f[1] = mk(2'b00, 4'd9, 4'd9, 54'h2002);
        f[2] = mk(2'b10, 4'd9, 4'd9, 54'h2003);
        for (int i = 0; i < 3; i++) begin
            send(f[i]);
            expect_out(f[i], 3'd4);
            tick;
        end
        link_valid = 1'b0;
        repeat (2) tick;
        chk("pkt_occ_after", 64'(occupancy), 64'd0);

        // Fill to DEPTH with back-pressure; fifth flit refused
        ready_in = 1'b0;
        f[0] = mk(2'b11, 4'd1, 4'd1, 54'h3001);
        f[1] = mk(2'b11, 4'd1, 4'd3, 54'h3002);
        f[2] = mk(2'b11, 4'd1, 4'd0, 54'h3003);
        f[3] = mk(2'b11, 4'd2, 4'd0, 54'h3004);
        expect_out(f[0], 3'd0);
        expect_out(f[1], 3'd1);
        expect_out(f[2], 3'd3);
        expect_out(f[3], 3'd2);
        for (int i = 0; i < 4; i++) begin
            send(f[i]);
            tick;
        end
        chk("fill_occ", 64'(occupancy), 64'd4);
        chk("fill_link_ready", 64'(link_ready), 64'd0);
        send(mk(2'b11, 4'd0, 4'd0, 54'h3BAD));
        tick;
        link_valid = 1'b0;
        chk("fill_occ_no_push", 64'(occupancy), 64'd4);
        chk("fill_head_stable", flit_out, f[0]);
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("drain_occ", 64'(occupancy), 64'(3 - i));
        end

        // Full with concurrent pop: push refused that cycle, accepted the next
        ready_in = 1'b0;
        f[0] = mk(2'b11, 4'd0, 4'd1, 54'h4001);
        f[1] = mk(2'b11, 4'd0, 4'd0, 54'h4002);
        f[2] = mk(2'b11, 4'd1, 4'd2, 54'h4003);
        f[3] = mk(2'b11, 4'd1, 4'd1, 54'h4004);
        f[4] = mk(2'b11, 4'd15, 4'd15, 54'h4005);
        expect_out(f[0], 3'd4);
        expect_out(f[1], 3'd4);
        expect_out(f[2], 3'd1);
        expect_out(f[3], 3'd0);
        expect_out(f[4], 3'd2);
        for (int i = 0; i < 4; i++) begin
            send(f[i]);
            tick;
        end
        ready_in = 1'b1;
        send(f[4]);
        tick;
        chk("full_pop_occ", 64'(occupancy), 64'd3);
        tick;
        link_valid = 1'b0;
        chk("full_push_next_occ", 64'(occupancy), 64'd3);
        repeat (3) tick;
        chk("full_drain_occ", 64'(occupancy), 64'd0);

        // Orphan body while IDLE, then orphan tail under back-pressure
        send(mk(2'b00, 4'd2, 4'd2, 54'h5001));
        tick;
        link_valid = 1'b0;
        chk("orphan_valid", 64'(valid_out), 64'd0);
        chk("orphan_err", 64'(err_orphan), 64'd1);
        tick;
        chk("orphan_err_clear", 64'(err_orphan), 64'd0);
        chk("orphan_occ", 64'(occupancy), 64'd0);
`ifdef NOC_IBUF_STATS_EN
        chk("drop_count_1", 64'(drop_count), 64'd1);
`endif
        ready_in = 1'b0;
        send(mk(2'b10, 4'd2, 4'd2, 54'h5002));
        tick;
        link_valid = 1'b0;
        chk("orphan_tail_err", 64'(err_orphan), 64'd1);
        chk("orphan_tail_valid", 64'(valid_out), 64'd0);
        tick;
        chk("orphan_tail_occ", 64'(occupancy), 64'd0);
`ifdef NOC_IBUF_STATS_EN
        chk("drop_count_2", 64'(drop_count), 64'd2);
`endif

        // Reset mid-packet, then a fresh head computes its own route
        ready_in = 1'b1;
        f[0] = mk(2'b01, 4'd2, 4'd2, 54'h6001);
        send(f[0]);
        expect_out(f[0], 3'd2);
        tick;
        send(mk(2'b00, 4'd0, 4'd0, 54'h6002));
        tick;
        link_valid = 1'b0;
        ready_in   = 1'b0;
        chk("mid_route_held", 64'(route_port), 64'd2);
        chk("mid_occ", 64'(occupancy), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_valid", 64'(valid_out), 64'd0);
        chk("mid_rst_route", 64'(route_port), 64'd0);
        chk("mid_rst_link_ready", 64'(link_ready), 64'd1);
        f[1] = mk(2'b01, 4'd1, 4'd0, 54'h6003);
        f[2] = mk(2'b10, 4'd0, 4'd0, 54'h6004);
        send(f[1]);
        tick;
        link_valid = 1'b0;
        chk("fresh_route", 64'(route_port), 64'd3);
        chk("fresh_valid", 64'(valid_out), 64'd1);
        expect_out(f[1], 3'd3);
        expect_out(f[2], 3'd3);
        ready_in = 1'b1;
        send(f[2]);
        tick;
        link_valid = 1'b0;
        repeat (2) tick;
        chk("fresh_occ", 64'(occupancy), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
